// File: rtl/branch_rs_scheduler.sv
// Branch reservation station: holds ops, snoops the CDB, issues the oldest ready op to the branch ALU.
// Operands ok -> result 1 cycle later; issue stalls while full, fire stalls while the result slot is held.
module branch_rs_scheduler #(
  parameter int RS_SIZE = 4,
  parameter int ROB_IX  = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              flush_in,
  input  logic              issue_valid_in,
  output logic              issue_ready_out,
  input  logic [2:0]        issue_func_in,
  input  logic [ROB_IX:0]   issue_tag_in,
  input  logic [31:0]       issue_pc_in,
  input  logic [31:0]       issue_imm_in,
  input  logic              issue_v1ok_in,
  input  logic [31:0]       issue_v1_in,
  input  logic [ROB_IX:0]   issue_q1_in,
  input  logic              issue_v2ok_in,
  input  logic [31:0]       issue_v2_in,
  input  logic [ROB_IX:0]   issue_q2_in,
  input  logic              cdb_valid_in,
  input  logic [ROB_IX:0]   cdb_tag_in,
  input  logic [31:0]       cdb_value_in,
  output logic [31:0]       alu_rval1_out,
  output logic [31:0]       alu_rval2_out,
  output logic [2:0]        alu_func_out,
  input  logic              alu_bool_in,
  output logic              res_valid_out,
  input  logic              res_ready_in,
  output logic [ROB_IX:0]   res_tag_out,
  output logic              res_taken_out,
  output logic [31:0]       res_target_out,
  output logic [31:0]       res_link_out
);
  localparam int IXW = $clog2(RS_SIZE);
  localparam logic [2:0] FN_DBR = 3'd6;

  typedef struct packed {
    logic [2:0]      func;
    logic [ROB_IX:0] tag;
    logic [31:0]     pc;
    logic [31:0]     imm;
    logic            v1ok;
    logic [31:0]     v1;
    logic [ROB_IX:0] q1;
    logic            v2ok;
    logic [31:0]     v2;
    logic [ROB_IX:0] q2;
    logic [IXW-1:0]  rank;
  } ent_t;

  logic [RS_SIZE-1:0] r_vld;
  ent_t               r_ent [RS_SIZE];

  logic [RS_SIZE-1:0] w_vld_nxt;
  ent_t               w_ent_nxt [RS_SIZE];
  ent_t               w_new;
  logic [IXW:0]       w_cnt;
  logic [IXW-1:0]     w_free_idx;
  logic               w_sel_found;
  logic [IXW-1:0]     w_sel_idx;
  logic [IXW-1:0]     w_sel_rank;
  logic               w_fire;
  logic               w_alloc;
  logic               w_res_taken;
  logic [31:0]        w_res_target;

  always_comb begin
    w_cnt      = '0;
    w_free_idx = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      w_cnt = w_cnt + {{IXW{1'b0}}, r_vld[i]};
    end
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!r_vld[i]) w_free_idx = IXW'(i);
    end
  end

  assign issue_ready_out = (w_cnt != (IXW+1)'(RS_SIZE));
  assign w_alloc         = issue_valid_in & issue_ready_out & ~flush_in;

  // Readiness uses registered ok bits only; a CDB capture becomes selectable next cycle.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    w_sel_rank  = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (r_vld[i] && r_ent[i].v1ok && r_ent[i].v2ok &&
          (!w_sel_found || r_ent[i].rank < w_sel_rank)) begin
        w_sel_found = 1'b1;
        w_sel_idx   = IXW'(i);
        w_sel_rank  = r_ent[i].rank;
      end
    end
  end

  assign w_fire        = w_sel_found & (~res_valid_out | res_ready_in);
  assign alu_rval1_out = w_sel_found ? r_ent[w_sel_idx].v1   : 32'd0;
  assign alu_rval2_out = w_sel_found ? r_ent[w_sel_idx].v2   : 32'd0;
  assign alu_func_out  = w_sel_found ? r_ent[w_sel_idx].func : 3'd0;

  assign w_res_taken  = (r_ent[w_sel_idx].func == FN_DBR) ? 1'b1 : alu_bool_in;
  assign w_res_target = (r_ent[w_sel_idx].func == FN_DBR)
                        ? ((r_ent[w_sel_idx].v1 + r_ent[w_sel_idx].imm) & 32'hFFFF_FFFE)
                        : (r_ent[w_sel_idx].pc + r_ent[w_sel_idx].imm);

  // Incoming op snoops the CDB too, so a broadcast in its issue cycle is not lost.
  always_comb begin
    w_new.func = issue_func_in;
    w_new.tag  = issue_tag_in;
    w_new.pc   = issue_pc_in;
    w_new.imm  = issue_imm_in;
    w_new.v1ok = issue_v1ok_in;
    w_new.v1   = issue_v1_in;
    w_new.q1   = issue_q1_in;
    w_new.v2ok = issue_v2ok_in;
    w_new.v2   = issue_v2_in;
    w_new.q2   = issue_q2_in;
    w_new.rank = IXW'(w_cnt - {{IXW{1'b0}}, w_fire});
    if (cdb_valid_in && !issue_v1ok_in && issue_q1_in == cdb_tag_in) begin
      w_new.v1ok = 1'b1;
      w_new.v1   = cdb_value_in;
    end
    if (cdb_valid_in && !issue_v2ok_in && issue_q2_in == cdb_tag_in) begin
      w_new.v2ok = 1'b1;
      w_new.v2   = cdb_value_in;
    end
  end

  always_comb begin
    w_vld_nxt = r_vld;
    w_ent_nxt = r_ent;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (r_vld[i]) begin
        if (w_fire && w_sel_idx == IXW'(i)) begin
          w_vld_nxt[i] = 1'b0;
        end else begin
          if (w_fire && r_ent[i].rank > w_sel_rank)
            w_ent_nxt[i].rank = r_ent[i].rank - IXW'(1);
          if (cdb_valid_in && !r_ent[i].v1ok && r_ent[i].q1 == cdb_tag_in) begin
            w_ent_nxt[i].v1ok = 1'b1;
            w_ent_nxt[i].v1   = cdb_value_in;
          end
          if (cdb_valid_in && !r_ent[i].v2ok && r_ent[i].q2 == cdb_tag_in) begin
            w_ent_nxt[i].v2ok = 1'b1;
            w_ent_nxt[i].v2   = cdb_value_in;
          end
        end
      end
    end
    if (w_alloc) begin
      w_vld_nxt[w_free_idx] = 1'b1;
      w_ent_nxt[w_free_idx] = w_new;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_vld          <= '0;
      for (int i = 0; i < RS_SIZE; i++) r_ent[i] <= '0;
      res_valid_out  <= 1'b0;
      res_tag_out    <= '0;
      res_taken_out  <= 1'b0;
      res_target_out <= '0;
      res_link_out   <= '0;
    end else if (flush_in) begin
      r_vld         <= '0;
      res_valid_out <= 1'b0;
    end else begin
      r_vld <= w_vld_nxt;
      for (int i = 0; i < RS_SIZE; i++) r_ent[i] <= w_ent_nxt[i];
      if (w_fire) begin
        res_valid_out  <= 1'b1;
        res_tag_out    <= r_ent[w_sel_idx].tag;
        res_taken_out  <= w_res_taken;
        res_target_out <= w_res_target;
        res_link_out   <= r_ent[w_sel_idx].pc + 32'd4;
      end else if (res_ready_in) begin
        res_valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_branch_rs_scheduler.sv
// Directed bench for branch_rs_scheduler with a behavioural branch ALU.
module tb_branch_rs_scheduler;
  logic        clk_in = 1'b0;
  logic        rst_in, flush_in;
  logic        issue_valid_in, issue_ready_out;
  logic [2:0]  issue_func_in;
  logic [2:0]  issue_tag_in, issue_q1_in, issue_q2_in;
  logic [31:0] issue_pc_in, issue_imm_in, issue_v1_in, issue_v2_in;
  logic        issue_v1ok_in, issue_v2ok_in;
  logic        cdb_valid_in;
  logic [2:0]  cdb_tag_in;
  logic [31:0] cdb_value_in;
  logic [31:0] alu_rval1_out, alu_rval2_out;
  logic [2:0]  alu_func_out;
  logic        alu_bool_in;
  logic        res_valid_out, res_ready_in, res_taken_out;
  logic [2:0]  res_tag_out;
  logic [31:0] res_target_out, res_link_out;

  int n_chk = 0;
  int n_err = 0;

  branch_rs_scheduler #(.RS_SIZE(4), .ROB_IX(2)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .flush_in(flush_in),
    .issue_valid_in(issue_valid_in), .issue_ready_out(issue_ready_out),
    .issue_func_in(issue_func_in), .issue_tag_in(issue_tag_in),
    .issue_pc_in(issue_pc_in), .issue_imm_in(issue_imm_in),
    .issue_v1ok_in(issue_v1ok_in), .issue_v1_in(issue_v1_in), .issue_q1_in(issue_q1_in),
    .issue_v2ok_in(issue_v2ok_in), .issue_v2_in(issue_v2_in), .issue_q2_in(issue_q2_in),
    .cdb_valid_in(cdb_valid_in), .cdb_tag_in(cdb_tag_in), .cdb_value_in(cdb_value_in),
    .alu_rval1_out(alu_rval1_out), .alu_rval2_out(alu_rval2_out),
    .alu_func_out(alu_func_out), .alu_bool_in(alu_bool_in),
    .res_valid_out(res_valid_out), .res_ready_in(res_ready_in),
    .res_tag_out(res_tag_out), .res_taken_out(res_taken_out),
    .res_target_out(res_target_out), .res_link_out(res_link_out)
  );

  always #5 clk_in = ~clk_in;

  always_comb begin
    case (alu_func_out)
      3'd0: alu_bool_in = (alu_rval1_out == alu_rval2_out);
      3'd1: alu_bool_in = (alu_rval1_out != alu_rval2_out);
      3'd2: alu_bool_in = ($signed(alu_rval1_out) < $signed(alu_rval2_out));
      3'd3: alu_bool_in = (alu_rval1_out < alu_rval2_out);
      3'd4: alu_bool_in = ($signed(alu_rval1_out) >= $signed(alu_rval2_out));
      3'd5: alu_bool_in = (alu_rval1_out >= alu_rval2_out);
      default: alu_bool_in = 1'b0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic put(input logic [2:0] fn, input logic [2:0] tg, input logic [31:0] pc,
                     input logic [31:0] imm, input logic ok1, input logic [31:0] v1,
                     input logic [2:0] q1, input logic ok2, input logic [31:0] v2,
                     input logic [2:0] q2);
    issue_valid_in = 1'b1;
    issue_func_in  = fn;  issue_tag_in = tg;
    issue_pc_in    = pc;  issue_imm_in = imm;
    issue_v1ok_in  = ok1; issue_v1_in  = v1; issue_q1_in = q1;
    issue_v2ok_in  = ok2; issue_v2_in  = v2; issue_q2_in = q2;
  endtask

  task automatic cdb(input logic [2:0] tg, input logic [31:0] val);
    cdb_valid_in = 1'b1;
    cdb_tag_in   = tg;
    cdb_value_in = val;
  endtask

  // Slot held with tag7, three entries waiting on tag5, plus one ready op offered.
  task automatic load_for_kill();
    res_ready_in = 1'b0;
    put(3'd0, 3'd7, 32'h10, 32'h4, 1, 32'd1, 0, 1, 32'd1, 0);
    tick();
    issue_valid_in = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      put(3'd0, 3'(k), 32'h20, 32'h4, 0, 32'd0, 3'd5, 1, 32'd0, 0);
      tick();
    end
    put(3'd1, 3'd6, 32'h30, 32'h4, 1, 32'd1, 0, 1, 32'd2, 0);
    cdb(3'd5, 32'd0);
  endtask

  initial begin
    rst_in = 1'b0; flush_in = 1'b0; issue_valid_in = 1'b0;
    issue_func_in = '0; issue_tag_in = '0; issue_pc_in = '0; issue_imm_in = '0;
    issue_v1ok_in = 1'b0; issue_v1_in = '0; issue_q1_in = '0;
    issue_v2ok_in = 1'b0; issue_v2_in = '0; issue_q2_in = '0;
    cdb_valid_in = 1'b0; cdb_tag_in = '0; cdb_value_in = '0;
    res_ready_in = 1'b1;
    tick(); tick();
    rst_in = 1'b1;
    chk("rst_res_valid", 32'(res_valid_out), 32'd0);
    chk("rst_res_target", res_target_out, 32'd0);
    chk("rst_issue_ready", 32'(issue_ready_out), 32'd1);
    chk("rst_alu_rval1", alu_rval1_out, 32'd0);

    // Eq, both operands present
    put(3'd0, 3'd1, 32'h100, 32'h20, 1, 32'd5, 0, 1, 32'd5, 0);
    tick();
    issue_valid_in = 1'b0;
    #1 chk("eq_alu_rval1", alu_rval1_out, 32'd5);
    tick();
    chk("eq_valid", 32'(res_valid_out), 32'd1);
    chk("eq_tag", 32'(res_tag_out), 32'd1);
    chk("eq_taken", 32'(res_taken_out), 32'd1);
    chk("eq_target", res_target_out, 32'h120);
    chk("eq_link", res_link_out, 32'h104);
    tick();
    chk("eq_drained", 32'(res_valid_out), 32'd0);

    // Lt with operand2 woken by the CDB
    put(3'd2, 3'd2, 32'h200, 32'hFFFF_FFF0, 1, 32'hFFFF_FFFF, 0, 0, 32'd0, 3'd3);
    tick();
    issue_valid_in = 1'b0;
    tick();
    cdb(3'd3, 32'd0);
    tick();
    cdb_valid_in = 1'b0;
    chk("lt_not_yet", 32'(res_valid_out), 32'd0);
    tick();
    chk("lt_valid", 32'(res_valid_out), 32'd1);
    chk("lt_taken", 32'(res_taken_out), 32'd1);
    chk("lt_target", res_target_out, 32'h1F0);
    tick();

    // Fill all entries; idx0 and idx2 both wait on tag7
    put(3'd0, 3'd4, 32'h0, 32'h0, 0, 32'd0, 3'd7, 1, 32'd9, 0); tick();
    put(3'd0, 3'd5, 32'h0, 32'h0, 0, 32'd0, 3'd1, 1, 32'd0, 0); tick();
    put(3'd0, 3'd6, 32'h0, 32'h0, 0, 32'd0, 3'd7, 1, 32'd8, 0); tick();
    put(3'd0, 3'd0, 32'h0, 32'h0, 0, 32'd0, 3'd2, 1, 32'd0, 0); tick();
    chk("full_ready", 32'(issue_ready_out), 32'd0);
    put(3'd0, 3'd3, 32'h0, 32'h0, 1, 32'd0, 0, 1, 32'd0, 0); tick();
    issue_valid_in = 1'b0;
    chk("full_refused", 32'(issue_ready_out), 32'd0);
    chk("full_no_fire", 32'(res_valid_out), 32'd0);
    cdb(3'd7, 32'd9);
    tick();
    cdb_valid_in = 1'b0;
    tick();
    chk("wake_first_tag", 32'(res_tag_out), 32'd4);
    chk("wake_first_taken", 32'(res_taken_out), 32'd1);
    chk("wake_ready_again", 32'(issue_ready_out), 32'd1);
    tick();
    chk("wake_second_valid", 32'(res_valid_out), 32'd1);
    chk("wake_second_tag", 32'(res_tag_out), 32'd6);
    chk("wake_second_taken", 32'(res_taken_out), 32'd0);
    flush_in = 1'b1; tick(); flush_in = 1'b0;

    // Backpressure on the result slot
    res_ready_in = 1'b0;
    put(3'd1, 3'd1, 32'h300, 32'h8, 1, 32'd1, 0, 1, 32'd2, 0); tick();
    put(3'd5, 3'd2, 32'h400, 32'h10, 1, 32'd3, 0, 1, 32'd3, 0); tick();
    issue_valid_in = 1'b0;
    tick(); tick();
    chk("bp_held_valid", 32'(res_valid_out), 32'd1);
    chk("bp_held_tag", 32'(res_tag_out), 32'd1);
    chk("bp_held_target", res_target_out, 32'h308);
    res_ready_in = 1'b1;
    tick();
    chk("bp_next_valid", 32'(res_valid_out), 32'd1);
    chk("bp_next_tag", 32'(res_tag_out), 32'd2);
    chk("bp_next_target", res_target_out, 32'h410);
    tick();
    chk("bp_empty", 32'(res_valid_out), 32'd0);

    // Dbr then Ltu
    put(3'd6, 3'd3, 32'h40, 32'h4, 1, 32'h2001, 0, 1, 32'd0, 0); tick();
    issue_valid_in = 1'b0;
    tick();
    chk("dbr_taken", 32'(res_taken_out), 32'd1);
    chk("dbr_target", res_target_out, 32'h2004);
    chk("dbr_link", res_link_out, 32'h44);
    put(3'd3, 3'd4, 32'h80, 32'h100, 1, 32'hFFFF_FFFF, 0, 1, 32'd1, 0); tick();
    issue_valid_in = 1'b0;
    tick();
    chk("ltu_tag", 32'(res_tag_out), 32'd4);
    chk("ltu_taken", 32'(res_taken_out), 32'd0);
    chk("ltu_target", res_target_out, 32'h180);
    tick();

    // Flush with entries, full slot, issue and CDB in the same cycle
    load_for_kill();
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0; issue_valid_in = 1'b0; cdb_valid_in = 1'b0; res_ready_in = 1'b1;
    chk("flush_res_valid", 32'(res_valid_out), 32'd0);
    chk("flush_issue_ready", 32'(issue_ready_out), 32'd1);
    chk("flush_alu_idle", 32'(alu_func_out), 32'd0);
    cdb(3'd5, 32'd0);
    tick();
    cdb_valid_in = 1'b0;
    tick();
    chk("flush_no_ghost", 32'(res_valid_out), 32'd0);

    // Same scenario cleared by reset
    load_for_kill();
    rst_in = 1'b0;
    tick();
    rst_in = 1'b1; issue_valid_in = 1'b0; cdb_valid_in = 1'b0; res_ready_in = 1'b1;
    chk("rst2_res_valid", 32'(res_valid_out), 32'd0);
    chk("rst2_res_tag", 32'(res_tag_out), 32'd0);
    chk("rst2_issue_ready", 32'(issue_ready_out), 32'd1);
    chk("rst2_alu_rval2", alu_rval2_out, 32'd0);
    cdb(3'd5, 32'd0);
    tick();
    cdb_valid_in = 1'b0;
    tick();
    chk("rst2_no_ghost", 32'(res_valid_out), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
